// File: rtl/adder_arbiter.sv
// Arbitrates NUM_REQ requesters onto one pipelined adder and returns tagged results.
// Define ADDER_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 25,
  parameter int ADD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        hold,
  output logic [WIDTH-1:0]            add_a,
  output logic [WIDTH-1:0]            add_b,
  input  logic [WIDTH-1:0]            add_sum,
  input  logic                        add_overflow,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_overflow,
  output logic                        busy
);

  // state | meaning
  // IDLE  | no tags in flight, grants allowed
  // RUN   | issuing and/or tags in flight
  // FLUSH | hold seen with tags in flight; no grants until drained

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              found;
  logic [ID_W-1:0]   gnt_idx;
  logic              xfer;
  logic [WIDTH-1:0]  sel_a, sel_b;

  logic [ADD_LAT-1:0] tag_vld, tag_vld_nxt;
  logic [ID_W-1:0]    tag_id [ADD_LAT];
  logic               any_nxt;

`ifdef ADDER_ARB_RR_EN
  // rr_ptr holds the index where the next search starts (last grant + 1)
  logic [ID_W-1:0] rr_ptr;
  int              cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[k]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(k);
      end
    end
  end
`endif

  assign xfer = found & ~hold & (state != FLUSH) & rst_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a <= '0;
      add_b <= '0;
    end else if (xfer) begin
      add_a <= sel_a;
      add_b <= sel_b;
    end
  end

  always_comb begin
    tag_vld_nxt    = '0;
    tag_vld_nxt[0] = xfer;
    for (int k = 1; k < ADD_LAT; k++) tag_vld_nxt[k] = tag_vld[k-1];
  end

  assign any_nxt = |tag_vld_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int k = 0; k < ADD_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= tag_vld_nxt;
      tag_id[0] <= gnt_idx;
      for (int k = 1; k < ADD_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (xfer) state_nxt = RUN;
      RUN: begin
        if (hold && any_nxt) state_nxt = FLUSH;
        else if (!any_nxt)   state_nxt = IDLE;
      end
      FLUSH: if (!any_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = |tag_vld;
  assign rsp_valid    = tag_vld[ADD_LAT-1];
  assign rsp_id       = rsp_valid ? tag_id[ADD_LAT-1] : '0;
  assign rsp_sum      = rsp_valid ? add_sum : '0;
  assign rsp_overflow = rsp_valid ? add_overflow : 1'b0;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural one-register adder and a response scoreboard.
module tb_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 25;
  localparam int ADD_LAT = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     hold;
  logic [WIDTH-1:0]         add_a, add_b, add_sum;
  logic                     add_overflow;
  logic                     rsp_valid;
  logic [1:0]               rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_overflow;
  logic                     busy;

  adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .hold(hold), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_overflow(add_overflow), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // adder_top stand-in: one register stage after the arbiter's operand register
  always @(posedge clk) begin
    if (!rst_n) {add_overflow, add_sum} <= '0;
    else        {add_overflow, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
  end

  typedef struct {
    int               id;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    int               cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got id=%0d sum=%h ovf=%0d at cyc %0d, required no response",
                   rsp_id, rsp_sum, rsp_overflow, cyc);
        end else begin
          mon_e = q.pop_front();
          if (int'(rsp_id) != mon_e.id || rsp_sum !== mon_e.sum ||
              rsp_overflow !== mon_e.ovf || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL rsp: got id=%0d sum=%h ovf=%0d cyc=%0d, required id=%0d sum=%h ovf=%0d cyc=%0d",
                     rsp_id, rsp_sum, rsp_overflow, cyc, mon_e.id, mon_e.sum, mon_e.ovf, mon_e.cyc);
          end
        end
      end else if (rsp_id !== '0 || rsp_sum !== '0 || rsp_overflow !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_idle_zero: got id=%0d sum=%h ovf=%0d, required all zero",
                 rsp_id, rsp_sum, rsp_overflow);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // applies inputs now, checks the grant mid-cycle, returns 1 time unit after the next rising edge
  task automatic drive_cycle(input logic [3:0] v, input logic h, input int g, input logic push,
                             input logic [WIDTH-1:0] es, input logic eo);
    logic [3:0] e;
    req_valid = v;
    hold      = h;
    @(negedge clk);
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(e));
    if (push) q.push_back('{g, es, eo, cyc + ADD_LAT});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(4'b0000, 1'b0, -1, 1'b0, '0, 1'b0);
  endtask

  int               gseq [5];
  logic [WIDTH-1:0] sums [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ADDER_ARB_RR_EN
    gseq = '{0, 1, 2, 3, 0};
`else
    gseq = '{0, 0, 0, 0, 0};
`endif
    sums = '{25'h0000103, 25'h0000204, 25'h0000305, 25'h0000406};
    req_valid = '0;
    hold      = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rst_n     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_busy",      32'(busy),      32'h0);
    chk("reset_add_a",     32'(add_a),     32'h0);
    chk("reset_state",     32'(dut.state), 32'h0);

    set_op(0, 25'h0000100, 25'h0000003);
    set_op(1, 25'h0000200, 25'h0000004);
    set_op(2, 25'h0000300, 25'h0000005);
    set_op(3, 25'h0000400, 25'h0000006);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all four requesting, first grant right after reset release
    for (int k = 0; k < 5; k++) drive_cycle(4'b1111, 1'b0, gseq[k], 1'b1, sums[gseq[k]], 1'b0);
    idle(3);

    set_op(2, 25'h0000005, 25'h0000003);
    drive_cycle(4'b0100, 1'b0, 2, 1'b1, 25'h0000008, 1'b0);
    idle(3);

    // back-to-back ops from one requester, carry into MSB then carry-out
    set_op(1, 25'h0FFFFFF, 25'h0000001);
    drive_cycle(4'b0010, 1'b0, 1, 1'b1, 25'h1000000, 1'b0);
    set_op(1, 25'h1FFFFFF, 25'h0000001);
    drive_cycle(4'b0010, 1'b0, 1, 1'b1, 25'h0000000, 1'b1);
    idle(3);

    // hold in the same cycle as valid: nothing consumed
    set_op(3, 25'h0000123, 25'h0000456);
    drive_cycle(4'b1000, 1'b1, -1, 1'b0, '0, 1'b0);
    chk("add_a_held", 32'(add_a), 32'h01FFFFFF);
    drive_cycle(4'b1000, 1'b0, 3, 1'b1, 25'h0000579, 1'b0);
    chk("add_a_loaded", 32'(add_a), 32'h00000123);
    idle(3);

    // two ops then hold: drain through FLUSH
    set_op(0, 25'h0000010, 25'h0000020);
    drive_cycle(4'b0001, 1'b0, 0, 1'b1, 25'h0000030, 1'b0);
    drive_cycle(4'b0001, 1'b0, 0, 1'b1, 25'h0000030, 1'b0);
    drive_cycle(4'b1111, 1'b1, -1, 1'b0, '0, 1'b0);
    chk("flush_state", 32'(dut.state), 32'h2);
    chk("flush_busy",  32'(busy),      32'h1);
    drive_cycle(4'b1111, 1'b1, -1, 1'b0, '0, 1'b0);
    chk("drained_state", 32'(dut.state), 32'h0);
    chk("drained_busy",  32'(busy),      32'h0);
    idle(2);

    // reset mid-operation discards the in-flight op
    set_op(0, 25'h0000007, 25'h0000008);
    drive_cycle(4'b0001, 1'b0, 0, 1'b0, '0, 1'b0);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
